// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Brief    : Shared types and constants for the 3-to-8 strobe decoder and its
//            companion 8-to-3 one-hot encoder.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Width of the binary code and number of decoded lines
    localparam int CODE_W = 3;
    localparam int LINES  = 8;

    // Decoder control state
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Binary code to one-hot select
    function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
        return LINES'(1) << code;
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder3x8_strobe_if.sv
`default_nettype none
// ============================================================================
// Module   : decoder3x8_strobe_if
// Brief    : Code handshake and strobe outputs of the 3-to-8 strobe decoder.
//            master = code producer, slave = decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface decoder3x8_strobe_if
    import decoder_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in;
    logic              in_par;
    logic [LINES-1:0]  out;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output in_valid,
        output in,
        output in_par,
        input  in_ready,
        input  out,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in,
        input  in_par,
        output in_ready,
        output out,
        output busy,
        output done,
        output err
    );

endinterface : decoder3x8_strobe_if
`default_nettype wire

// File: rtl/decoder3x8_strobe.sv
`default_nettype none
// ============================================================================
// Module   : decoder3x8_strobe
// Brief    : Registered 3-to-8 one-hot decoder. A code accepted over a
//            valid/ready handshake drives its one-hot line for exactly
//            PULSE_CYCLES clocks, then done pulses as the line drops.
//            Optional macro DEC_PARITY_EN: require even parity on
//            {in_par,in}; bad-parity codes are consumed, raise err for one
//            cycle and produce no strobe.
// Revision : 1.0 - initial release
// ============================================================================
module decoder3x8_strobe
    import decoder_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    decoder3x8_strobe_if.slave bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((PULSE_CYCLES < 1) || (PULSE_CYCLES > 255)) begin : g_bad_pulse
        $error("decoder3x8_strobe: PULSE_CYCLES=%0d outside 1..255", PULSE_CYCLES);
    end

    if ((2 ** CNT_W) <= PULSE_CYCLES) begin : g_bad_cnt_w
        $error("decoder3x8_strobe: CNT_W=%0d too narrow for PULSE_CYCLES=%0d",
               CNT_W, PULSE_CYCLES);
    end

    // Counter reload: the handshake edge already accounts for the first cycle
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(PULSE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [LINES-1:0]   r_out;
    logic [LINES-1:0]   w_out_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic               w_handshake;
    logic               w_par_ok;
    logic               w_in_ready;

    assign w_handshake = bus.in_valid && w_in_ready;

`ifdef DEC_PARITY_EN
    // Even parity over parity bit plus code
    assign w_par_ok = ~(^{bus.in_par, bus.in});
`else
    // Parity bit is not checked; every handshake starts a strobe
    assign w_par_ok = 1'b1;
    logic w_unused_par;
    assign w_unused_par = bus.in_par;
`endif

    // State register plus counter and registered outputs, async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, counter and strobe computation
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    if (w_par_ok) begin
                        w_out_nxt   = onehot(bus.in);
                        w_cnt_nxt   = c_cnt_load;
                        w_state_nxt = ACTIVE;
                    end else begin
                        // Code is consumed but rejected; stay idle
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end else begin
                    w_out_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_out_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Handshake/status outputs decoded from the current state
    always_comb begin
        w_in_ready = 1'b0;
        bus.busy   = 1'b0;
        case (r_state)
            IDLE:    w_in_ready = 1'b1;
            ACTIVE:  bus.busy   = 1'b1;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign bus.in_ready = w_in_ready;
    assign bus.out      = r_out;
    assign bus.done     = r_done;

`ifdef DEC_PARITY_EN
    assign bus.err      = r_err;
`else
    // Parity rejects cannot happen, so the err register is never set
    logic w_unused_err;
    assign w_unused_err = r_err;
    assign bus.err      = 1'b0;
`endif

endmodule : decoder3x8_strobe
`default_nettype wire

// File: doc/decoder3x8_strobe.md
Name: decoder3x8_strobe

Overview:
- Registered 3-to-8 one-hot decoder with a timed strobe: accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for exactly PULSE_CYCLES clocks.
- Companion to the 8-to-3 one-hot encoder. Used as a line or bank selector wherever an encoded index must become a timed one-hot select.
- Single clock domain. Output is fully registered.

Parameters:
- PULSE_CYCLES, 4, number of cycles the decoded line is held high. Legal range is 1..255; an elaboration error fires outside this range.
- CNT_W, 8, width of the pulse down-counter. Must satisfy 2**CNT_W > PULSE_CYCLES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  code presented
- in_ready  output  1  block can accept a code
- in  input  3  binary code 0..7
- in_par  input  1  parity bit; used only with DEC_PARITY_EN
- out  output  8  one-hot decoded strobe; all zeros when idle
- busy  output  1  strobe in progress
- done  output  1  one-cycle pulse on the cycle out returns to zero
- err  output  1  one-cycle pulse on a parity reject; tied 0 without DEC_PARITY_EN

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
  - While rst_n=0: out=8'h00, busy=0, done=0, err=0, state=IDLE, counter=0.
  - Reset asserted mid-strobe clears out immediately, without waiting for a clock edge.
- States: IDLE and ACTIVE. Signals are combinational from state:
  - in_ready = (state==IDLE)
  - busy = (state==ACTIVE)
- IDLE: a handshake occurs when in_valid && in_ready at a rising edge. On that edge:
  - out <= 8'b1 << in
  - counter <= PULSE_CYCLES-1
  - state <= ACTIVE
  - Latency: out is visible the cycle after the handshake.
- ACTIVE:
  - in_ready=0; in and in_valid are ignored, and in_valid may stay high without effect.
  - Each edge with counter!=0: counter decrements and out holds.
  - Edge with counter==0: out <= 0, done <= 1 for one cycle, state <= IDLE.
  - Net result: out is non-zero for exactly PULSE_CYCLES cycles.
- PULSE_CYCLES=1: out is high for one cycle, and done pulses the following cycle.
- Back-to-back codes: the earliest next handshake is the cycle in which done=1, because in_ready=1 again there. The next strobe starts the following edge.
  - Minimum one zero cycle on out between strobes.
  - out never has more than one bit set.
- Counter arithmetic: unsigned CNT_W bits. It never decrements below 0, so there is no wrap.
- done and err are registered pulses and are never asserted in the same cycle.

Optional Feature:
- Macro: DEC_PARITY_EN
- Defined:
  - Even parity is required: ^{in_par,in} must equal 0.
  - A handshake with bad parity is still accepted (in_ready was 1), but no strobe is generated.
  - err pulses high for one cycle on the next edge, and the state stays IDLE.
- Not defined: in_par is ignored, err is tied to 0, and every handshake starts a strobe.

Decomposition:
- Shared package decoder_pkg holds:
  - state enum {IDLE, ACTIVE}
  - constant CODE_W=3
  - constant LINES=8
  - function onehot(code) returning 8'b1<<code
- The encoder can reuse LINES and CODE_W from the same package.
- No sub-module; the counter and FSM are small enough to live inline.

Test Plan:
- Reset release, in_valid=0 for 10 cycles -> out=8'h00, in_ready=1, busy=0, done=0 throughout.
- PULSE_CYCLES=4, handshake in=3'd5 at cycle 0 -> out=8'h20 on cycles 1-4; out=0 and done=1 on cycle 5; in_ready=1 from cycle 5.
- Sweep in=0..7 with in_valid held high -> out sequence 01,02,04,…,80, each held 4 cycles, with one zero cycle between; in changes during ACTIVE are ignored.
- PULSE_CYCLES=1, in=3'd0 -> out=8'h01 for exactly one cycle, done on the next cycle.
- Drop rst_n low at cycle 2 of a strobe for in=3'd7 -> out=0 immediately (asynchronous); after release the block is IDLE and in_ready=1.
- DEC_PARITY_EN defined:
  - in=3'b011, in_par=1 -> bad parity: err=1 for one cycle, out stays 0.
  - in=3'b011, in_par=0 -> good parity: out=8'h08 strobe.
